// File: rtl/bp_nonsynth_commit_watchdog_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_commit_watchdog_if
// Brief    : Commit-record and report-record bundle for the commit watchdog.
//            The slave modport is the watchdog's view. The master modport is
//            the view of the core/testbench that feeds commits and consumes
//            reports.
// Revision : 1.0 - initial release
// ============================================================================
interface bp_nonsynth_commit_watchdog_if #(
    parameter int vaddr_width_p = 39,
    parameter int cnt_width_p   = 32
);

    // Retired-instruction record, one per cycle at most
    logic                     commit_v_i;
    logic                     trap_v_i;
    logic [vaddr_width_p-1:0] commit_pc_i;

    // Report record, valid/yumi handshake
    logic                     event_v_o;
    logic [1:0]               event_code_o;
    logic [vaddr_width_p-1:0] event_pc_o;
    logic [cnt_width_p-1:0]   event_cycle_o;
    logic                     event_yumi_i;

    // Watchdog side
    modport slave (
        input  commit_v_i,
        input  trap_v_i,
        input  commit_pc_i,
        input  event_yumi_i,
        output event_v_o,
        output event_code_o,
        output event_pc_o,
        output event_cycle_o
    );

    // Core / testbench side
    modport master (
        output commit_v_i,
        output trap_v_i,
        output commit_pc_i,
        output event_yumi_i,
        input  event_v_o,
        input  event_code_o,
        input  event_pc_o,
        input  event_cycle_o
    );

endinterface
`default_nettype wire

// File: rtl/bp_nonsynth_commit_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bp_nonsynth_commit_watchdog
// Brief    : Monitor on the retired-instruction stream. Detects forward-
//            progress stalls, same-PC livelock and arrival at a finish PC.
//            Each detection emits one report record and the block halts
//            until reset. Also counts retired non-trap instructions.
//            stall_timeout_p and loop_threshold_p are expected to be >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module bp_nonsynth_commit_watchdog #(
    parameter int vaddr_width_p    = 39,
    parameter int cnt_width_p      = 32,
    parameter int stall_timeout_p  = 65536,
    parameter int loop_threshold_p = 1024
) (
    input  wire logic                     clk_i,
    input  wire logic                     reset_n_i,
    input  wire logic                     en_i,
    input  wire logic                     freeze_i,
    input  wire logic [vaddr_width_p-1:0] finish_pc_i,
    bp_nonsynth_commit_watchdog_if.slave  commit_if,
    output logic [cnt_width_p-1:0]        instr_cnt_o,
    output logic                          halted_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Stall fires on the stall_timeout_p-th empty cycle, i.e. when the count
    // of previous empty cycles equals stall_timeout_p-1.
    localparam logic [cnt_width_p-1:0] c_stall_last  = cnt_width_p'(stall_timeout_p - 1);
    localparam logic [cnt_width_p-1:0] c_loop_thresh = cnt_width_p'(loop_threshold_p);
    localparam logic [cnt_width_p-1:0] c_cnt_one     = cnt_width_p'(1);
    localparam logic [cnt_width_p-1:0] c_cnt_max     = '1;

    localparam logic [1:0] c_code_none   = 2'd0;
    localparam logic [1:0] c_code_stall  = 2'd1;
    localparam logic [1:0] c_code_loop   = 2'd2;
    localparam logic [1:0] c_code_finish = 2'd3;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        e_idle   = 2'd0,
        e_run    = 2'd1,
        e_report = 2'd2,
        e_halted = 2'd3
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [cnt_width_p-1:0]   r_stall_cnt;
    logic [cnt_width_p-1:0]   r_loop_cnt;
    logic [cnt_width_p-1:0]   r_cycle_cnt;
    logic [cnt_width_p-1:0]   r_instr_cnt;
    logic [vaddr_width_p-1:0] r_last_pc;
    logic                     r_last_pc_v;

    logic [1:0]               r_ev_code;
    logic [vaddr_width_p-1:0] r_ev_pc;
    logic [cnt_width_p-1:0]   r_ev_cycle;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic                     w_active;
    logic                     w_retire;
    logic                     w_trap;
    logic                     w_same_pc;
    logic [cnt_width_p-1:0]   w_cycle_inc;
    logic [cnt_width_p-1:0]   w_stall_inc;
    logic [cnt_width_p-1:0]   w_instr_inc;
    logic [cnt_width_p-1:0]   w_loop_upd;
    logic                     w_finish_hit;
    logic                     w_loop_hit;
    logic                     w_stall_hit;
    logic                     w_detect;
    logic [1:0]               w_ev_code;
    logic [vaddr_width_p-1:0] w_ev_pc;

    // Counters stick at all-ones rather than wrapping to zero
    function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

    // Counting and detection only happen in run, enabled and not frozen
    assign w_active    = (r_state == e_run) & en_i & ~freeze_i;
    assign w_retire    = w_active & commit_if.commit_v_i & ~commit_if.trap_v_i;
    assign w_trap      = w_active & commit_if.commit_v_i &  commit_if.trap_v_i;

    assign w_cycle_inc = sat_inc(r_cycle_cnt);
    assign w_stall_inc = sat_inc(r_stall_cnt);
    assign w_instr_inc = sat_inc(r_instr_cnt);

    // A repeat of the last retired PC extends the run; anything else restarts it
    assign w_same_pc   = r_last_pc_v & (commit_if.commit_pc_i == r_last_pc);
    assign w_loop_upd  = w_same_pc ? sat_inc(r_loop_cnt) : c_cnt_one;

    assign w_finish_hit = w_retire & (finish_pc_i != '0)
                        & (commit_if.commit_pc_i == finish_pc_i);
    assign w_loop_hit   = w_retire & (w_loop_upd == c_loop_thresh);
    assign w_stall_hit  = w_active & ~commit_if.commit_v_i
                        & (r_stall_cnt == c_stall_last);
    assign w_detect     = w_finish_hit | w_loop_hit | w_stall_hit;

    // Report fields, priority finish > loop > stall
    always_comb begin
        w_ev_code = c_code_none;
        w_ev_pc   = '0;
        if (w_finish_hit) begin
            w_ev_code = c_code_finish;
            w_ev_pc   = commit_if.commit_pc_i;
        end else if (w_loop_hit) begin
            w_ev_code = c_code_loop;
            w_ev_pc   = commit_if.commit_pc_i;
        end else if (w_stall_hit) begin
            w_ev_code = c_code_stall;
            w_ev_pc   = r_last_pc_v ? r_last_pc : '0;
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_idle: begin
                if (en_i & ~freeze_i) begin
                    w_state_nxt = e_run;
                end
            end
            e_run: begin
                if (!en_i) begin
                    w_state_nxt = e_idle;
                end else if (w_detect) begin
                    w_state_nxt = e_report;
                end
            end
            e_report: begin
                if (commit_if.event_yumi_i) begin
                    w_state_nxt = e_halted;
                end
            end
            e_halted: begin
                w_state_nxt = e_halted;
            end
            default: begin
                w_state_nxt = e_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters and last-PC tracking
    // ------------------------------------------------------------------------
    // Update progress counters on each active run cycle; disabling resets the
    // stall/loop windows but keeps the lifetime counts and last PC
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_stall_cnt <= '0;
            r_loop_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_last_pc   <= '0;
            r_last_pc_v <= 1'b0;
        end else if ((r_state == e_run) && !en_i) begin
            r_stall_cnt <= '0;
            r_loop_cnt  <= '0;
        end else if (w_active) begin
            r_cycle_cnt <= w_cycle_inc;
            r_stall_cnt <= commit_if.commit_v_i ? '0 : w_stall_inc;
            if (w_retire) begin
                r_instr_cnt <= w_instr_inc;
                r_loop_cnt  <= w_loop_upd;
                r_last_pc   <= commit_if.commit_pc_i;
                r_last_pc_v <= 1'b1;
            end else if (w_trap) begin
                // A trap breaks any same-PC run; the next retire starts afresh
                r_loop_cnt  <= '0;
                r_last_pc_v <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Report capture
    // ------------------------------------------------------------------------
    // Latch the report fields on the detection cycle; they then stay stable
    // through report and halted until reset
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ev_code  <= c_code_none;
            r_ev_pc    <= '0;
            r_ev_cycle <= '0;
        end else if (w_detect) begin
            r_ev_code  <= w_ev_code;
            r_ev_pc    <= w_ev_pc;
            r_ev_cycle <= w_cycle_inc;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign commit_if.event_v_o     = (r_state == e_report);
    assign commit_if.event_code_o  = r_ev_code;
    assign commit_if.event_pc_o    = r_ev_pc;
    assign commit_if.event_cycle_o = r_ev_cycle;
    assign instr_cnt_o             = r_instr_cnt;
    assign halted_o                = (r_state == e_halted);

endmodule
`default_nettype wire

// File: tb/tb_bp_nonsynth_commit_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_nonsynth_commit_watchdog
// Brief    : Self-checking bench for the commit watchdog: commit counting,
//            stall, livelock, finish priority, report handshake, freeze,
//            enable drop and reset out of report.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_nonsynth_commit_watchdog;

    localparam int VA    = 39;
    localparam int CW    = 32;
    localparam int STALL = 16;
    localparam int LOOP  = 4;

    localparam logic [VA-1:0] c_base = 39'h0080000000;
    localparam logic [VA-1:0] c_lpc  = 39'h0080000100;
    localparam logic [VA-1:0] c_fpc  = 39'h0080000200;
    localparam logic [VA-1:0] c_zpc  = 39'h0080000300;
    localparam logic [VA-1:0] c_xpc  = 39'h0080000400;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          en_i;
    logic          freeze_i;
    logic [VA-1:0] finish_pc_i;
    logic [CW-1:0] instr_cnt_o;
    logic          halted_o;

    bp_nonsynth_commit_watchdog_if #(.vaddr_width_p(VA), .cnt_width_p(CW)) bus_if ();

    bp_nonsynth_commit_watchdog #(
        .vaddr_width_p   (VA),
        .cnt_width_p     (CW),
        .stall_timeout_p (STALL),
        .loop_threshold_p(LOOP)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n_i),
        .en_i       (en_i),
        .freeze_i   (freeze_i),
        .finish_pc_i(finish_pc_i),
        .commit_if  (bus_if),
        .instr_cnt_o(instr_cnt_o),
        .halted_o   (halted_o)
    );

    always #5 clk = ~clk;

    // Expected outputs after one clock edge
    typedef struct {
        logic          v;
        logic [1:0]    code;
        logic [VA-1:0] pc;
        logic [CW-1:0] instr;
        logic          halted;
    } exp_t;

    // One stimulus vector with its expected result
    typedef struct {
        logic          cv;
        logic          tv;
        logic [VA-1:0] pc;
        logic          yumi;
        logic          chk;
        exp_t          e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic v, input logic [1:0] code, input logic [VA-1:0] pc,
                                input logic [CW-1:0] instr, input logic halted);
        exp_t e;
        e.v      = v;
        e.code   = code;
        e.pc     = pc;
        e.instr  = instr;
        e.halted = halted;
        return e;
    endfunction

    function automatic vec_t mkv(input logic cv, input logic tv, input logic [VA-1:0] pc,
                                 input logic yumi, input logic chk, input exp_t e);
        vec_t r;
        r.cv   = cv;
        r.tv   = tv;
        r.pc   = pc;
        r.yumi = yumi;
        r.chk  = chk;
        r.e    = e;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at a negedge, queue the expectation, and
    // compare it against the outputs at the next negedge
    task automatic step(input string tag, input vec_t v);
        exp_t x;
        bus_if.commit_v_i   = v.cv;
        bus_if.trap_v_i     = v.tv;
        bus_if.commit_pc_i  = v.pc;
        bus_if.event_yumi_i = v.yumi;
        if (v.chk) sb.push_back(v.e);
        @(negedge clk);
        if (v.chk) begin
            x = sb.pop_front();
            check({tag, "/event_v"}, 64'(bus_if.event_v_o), 64'(x.v));
            check({tag, "/code"},    64'(bus_if.event_code_o), 64'(x.code));
            check({tag, "/instr"},   64'(instr_cnt_o), 64'(x.instr));
            check({tag, "/halted"},  64'(halted_o), 64'(x.halted));
            if (x.v) check({tag, "/event_pc"}, 64'(bus_if.event_pc_o), 64'(x.pc));
        end
    endtask

    task automatic do_reset(input string tag, input int n);
        reset_n_i           = 1'b0;
        bus_if.commit_v_i   = 1'b0;
        bus_if.trap_v_i     = 1'b0;
        bus_if.commit_pc_i  = '0;
        bus_if.event_yumi_i = 1'b0;
        repeat (n) @(negedge clk);
        check({tag, "/event_v"}, 64'(bus_if.event_v_o), 64'd0);
        check({tag, "/code"},    64'(bus_if.event_code_o), 64'd0);
        check({tag, "/halted"},  64'(halted_o), 64'd0);
        check({tag, "/instr"},   64'(instr_cnt_o), 64'd0);
        reset_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n_i           = 1'b0;
        en_i                = 1'b1;
        freeze_i            = 1'b0;
        finish_pc_i         = '0;
        bus_if.commit_v_i   = 1'b0;
        bus_if.trap_v_i     = 1'b0;
        bus_if.commit_pc_i  = '0;
        bus_if.event_yumi_i = 1'b0;

        // ---------------- table: commit counting and stall ----------------
        // idle -> run transition cycle, nothing counted
        tbl.push_back(mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));
        // 10 commits at distinct PCs; a stray yumi outside report is ignored
        for (int k = 0; k < 10; k++)
            tbl.push_back(mkv(1'b1, 1'b0, c_base + VA'(4 * k), (k == 3), 1'b1,
                              mk(1'b0, 2'd0, '0, CW'(k + 1), 1'b0)));
        // 15 empty cycles then a commit: no stall
        for (int k = 0; k < STALL - 1; k++)
            tbl.push_back(mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 10, 1'b0)));
        tbl.push_back(mkv(1'b1, 1'b0, c_base + VA'(40), 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 11, 1'b0)));
        // 16 empty cycles: the 16th is the detection cycle
        for (int k = 0; k < STALL - 1; k++)
            tbl.push_back(mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 11, 1'b0)));
        tbl.push_back(mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b1, 2'd1, c_base + VA'(40), 11, 1'b0)));
        // Held without yumi: report stays up
        tbl.push_back(mkv(1'b1, 1'b0, c_base, 1'b0, 1'b1, mk(1'b1, 2'd1, c_base + VA'(40), 11, 1'b0)));
        // Yumi -> halted next cycle, code retained
        tbl.push_back(mkv(1'b0, 1'b0, '0, 1'b1, 1'b1, mk(1'b0, 2'd1, '0, 11, 1'b1)));

        do_reset("reset1", 3);
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
            if (i == tbl.size() - 3)
                check("stall/cycle", 64'(bus_if.event_cycle_o), 64'd42);
        end

        // ---------------- livelock with trap break ----------------
        do_reset("reset2", 2);
        step("loop/idle", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));
        step("loop/c1",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 1, 1'b0)));
        step("loop/c2",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 2, 1'b0)));
        step("loop/trap", mkv(1'b1, 1'b1, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 2, 1'b0)));
        step("loop/c3",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 3, 1'b0)));
        step("loop/c4",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 4, 1'b0)));
        step("loop/c5",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 5, 1'b0)));
        step("loop/c6",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b1, 2'd2, c_lpc, 6, 1'b0)));
        check("loop/cycle", 64'(bus_if.event_cycle_o), 64'd7);
        step("loop/c7",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b1, 2'd2, c_lpc, 6, 1'b0)));
        step("loop/c8",   mkv(1'b1, 1'b0, c_lpc, 1'b0, 1'b1, mk(1'b1, 2'd2, c_lpc, 6, 1'b0)));

        // ---------------- finish coincident with loop ----------------
        do_reset("reset3", 2);
        step("fin/idle", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));
        for (int k = 0; k < 3; k++)
            step($sformatf("fin/c%0d", k), mkv(1'b1, 1'b0, c_fpc, 1'b0, 1'b1,
                                               mk(1'b0, 2'd0, '0, CW'(k + 1), 1'b0)));
        finish_pc_i = c_fpc;
        step("fin/hit", mkv(1'b1, 1'b0, c_fpc, 1'b0, 1'b1, mk(1'b1, 2'd3, c_fpc, 4, 1'b0)));
        check("fin/cycle", 64'(bus_if.event_cycle_o), 64'd4);
        for (int k = 0; k < 5; k++)
            step($sformatf("fin/hold%0d", k), mkv(1'b1, 1'b0, c_fpc + VA'(4), 1'b0, 1'b1,
                                                  mk(1'b1, 2'd3, c_fpc, 4, 1'b0)));
        check("fin/cycle_hold", 64'(bus_if.event_cycle_o), 64'd4);
        step("fin/yumi", mkv(1'b0, 1'b0, '0, 1'b1, 1'b1, mk(1'b0, 2'd3, '0, 4, 1'b1)));
        for (int k = 0; k < 3; k++)
            step($sformatf("fin/post%0d", k), mkv(1'b1, 1'b0, c_fpc, 1'b0, 1'b1,
                                                  mk(1'b0, 2'd3, '0, 4, 1'b1)));
        finish_pc_i = '0;

        // ---------------- freeze, enable drop, reset in report ----------------
        do_reset("reset4", 2);
        step("frz/idle", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));
        step("frz/c0",   mkv(1'b1, 1'b0, c_zpc, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 1, 1'b0)));
        freeze_i = 1'b1;
        for (int k = 0; k < 100; k++)
            step($sformatf("frz/f%0d", k), mkv((k % 3 == 0), 1'b0, c_xpc, 1'b0, 1'b1,
                                               mk(1'b0, 2'd0, '0, 1, 1'b0)));
        freeze_i = 1'b0;
        for (int k = 0; k < 5; k++)
            step($sformatf("frz/e%0d", k), mkv(1'b0, 1'b0, '0, 1'b0, 1'b1,
                                               mk(1'b0, 2'd0, '0, 1, 1'b0)));
        en_i = 1'b0;
        step("frz/en0", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 1, 1'b0)));
        en_i = 1'b1;
        step("frz/en1", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 1, 1'b0)));
        for (int k = 0; k < STALL - 1; k++)
            step($sformatf("frz/s%0d", k), mkv(1'b0, 1'b0, '0, 1'b0, 1'b1,
                                               mk(1'b0, 2'd0, '0, 1, 1'b0)));
        step("frz/stall", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b1, 2'd1, c_zpc, 1, 1'b0)));
        check("frz/cycle", 64'(bus_if.event_cycle_o), 64'd22);

        // Reset while the report is pending
        reset_n_i = 1'b0;
        step("rst/report", mkv(1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));
        check("rst/cycle", 64'(bus_if.event_cycle_o), 64'd0);
        reset_n_i = 1'b1;
        en_i      = 1'b0;
        step("rst/idle", mkv(1'b1, 1'b0, c_base, 1'b0, 1'b1, mk(1'b0, 2'd0, '0, 0, 1'b0)));

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: actual %0d leftover entries required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bp_nonsynth_commit_watchdog.md
Name: bp_nonsynth_commit_watchdog

Overview:
Non-synthesizable monitor on the retired-instruction stream. It sits beside the cosim checker on the same per-core commit records (valid, pc, instr, trap), and detects three conditions:
- forward-progress stalls
- same-PC livelock
- arrival at a programmed finish PC

Each detection produces one report record on a valid/yumi handshake to the testbench, after which the block halts. It also supplies a retired-instruction count.

Parameters:
vaddr_width_p, 39, width of commit PC and finish PC
cnt_width_p, 32, width of instruction and cycle counters (saturating)
stall_timeout_p, 65536, consecutive commit-free run cycles that constitute a stall (>=2)
loop_threshold_p, 1024, consecutive non-trap commits at one PC that constitute a livelock (>=2)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
en_i  in  1  watchdog enable
freeze_i  in  1  core frozen; all counting paused
finish_pc_i  in  vaddr_width_p  finish PC; 0 disables finish detection
commit_v_i  in  1  retire or trap record valid this cycle
trap_v_i  in  1  record is exception/interrupt (qualified by commit_v_i)
commit_pc_i  in  vaddr_width_p  PC of record
event_v_o  out  1  report record valid
event_code_o  out  2  1=stall, 2=loop, 3=finish (0 when idle)
event_pc_o  out  vaddr_width_p  captured PC
event_cycle_o  out  cnt_width_p  run-cycle count at detection
event_yumi_i  in  1  report consumed
instr_cnt_o  out  cnt_width_p  retired non-trap instructions
halted_o  out  1  watchdog halted after report

Behaviour:
- Reset: sampled on rising clk_i while reset_n_i=0.
  - State e_idle.
  - Counters cleared: stall_cnt, loop_cnt, cycle_cnt, instr_cnt.
  - last_pc and last_pc_v cleared.
  - All outputs 0.
  - Reset mid-report or while halted returns to e_idle the next cycle; no report is lost-checked.
- FSM states: e_idle, e_run, e_report, e_halted.
- e_idle -> e_run: when en_i & ~freeze_i. Otherwise stay; no counting.
- e_run, en_i=0: -> e_idle. stall_cnt and loop_cnt are cleared; instr_cnt, cycle_cnt and last_pc are kept.
- e_run, freeze_i=1: all counters hold; commit inputs are ignored.
- e_run, otherwise, per cycle:
  - cycle_cnt += 1 (saturating).
  - Any commit_v_i (trap or not) clears stall_cnt; else stall_cnt += 1.
  - Non-trap commit:
    - instr_cnt += 1 (saturating at all-ones).
    - If last_pc_v & pc==last_pc then loop_cnt += 1, else loop_cnt=1.
    - last_pc<=pc; last_pc_v<=1.
  - Trap commit: loop_cnt<=0, last_pc_v<=0, instr_cnt unchanged.
- Detection, evaluated combinationally in e_run (not frozen):
  - finish: non-trap commit with finish_pc_i!=0 and pc==finish_pc_i.
  - loop: non-trap commit whose loop_cnt update reaches loop_threshold_p.
  - stall: no commit and stall_cnt==stall_timeout_p-1, i.e. the stall_timeout_p-th consecutive empty cycle.
  - Priority: finish > loop > stall. Stall cannot coincide with the others.
- On detection cycle: latch event fields and go to e_report.
  - Code: per the detected condition.
  - PC: committing pc for finish/loop; last_pc for stall (0 if last_pc_v=0).
  - Cycle: cycle_cnt value after this cycle's increment.
- e_report:
  - event_v_o=1 with fields stable until event_yumi_i.
  - On event_yumi_i (while event_v_o=1): -> e_halted.
  - Commits are ignored; instr_cnt is frozen.
  - event_yumi_i asserted outside e_report is ignored.
- e_halted: halted_o=1; event_v_o=0; event_code_o holds last code; stays until reset.
- Latency: detection-cycle edge -> event_v_o=1 next cycle; yumi edge -> halted_o=1 next cycle.
- Saturation: counters stick at all-ones and never wrap. Stall/loop compares use full-width counters.

Test Plan:
- Reset held 3 cycles, en_i=1, 10 non-trap commits at distinct PCs 0x80000000+4k -> instr_cnt_o=10, event_v_o=0, halted_o=0.
- stall_timeout_p=16, one commit then 16 empty cycles -> event_v_o rises the cycle after the 16th empty cycle, code=1, pc=last committed PC. Same test with 15 empty cycles then a commit -> no event.
- loop_threshold_p=4, commits at 0x80000100 x4 with a trap inserted after the 2nd -> no event. Then 4 more non-trap commits at the same PC -> code=2, pc=0x80000100.
- finish_pc_i=0x80000200, commit at it in the same cycle loop would fire -> code=3. Hold event_yumi_i=0 for 5 cycles -> fields stable. Yumi -> halted_o=1 next cycle; further commits leave instr_cnt_o unchanged.
- freeze_i=1 for 100 cycles with stall_timeout_p=16 -> no stall event, cycle_cnt unchanged. en_i dropped mid-run then re-raised -> stall count restarts from 0.
- Reset asserted while in e_report -> next cycle event_v_o=0, halted_o=0, instr_cnt_o=0, state e_idle.
